// File: rtl/fp_pkg.sv
// Shared single-precision constants, FSM state encoding, flag positions and operand classification
// for the sequential floating-point add/subtract unit.
package fp_pkg;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CL_ZERO,
    CL_INF,
    CL_NAN,
    CL_NORMAL
  } fclass_t;

  // Denormals report as zero: the unit flushes them on input.
  function automatic fclass_t classify(input logic [EXP_W+MAN_W-1:0] mag);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e = mag[EXP_W+MAN_W-1:MAN_W];
    m = mag[MAN_W-1:0];
    if (e == '0)
      return CL_ZERO;
    else if (e == EXP_MAX)
      return (m == '0) ? CL_INF : CL_NAN;
    else
      return CL_NORMAL;
  endfunction
endpackage

// File: rtl/fp_addsub_seq_if.sv
// Operand request and result handshake bundle between the issuer/consumer and the add/sub unit.
interface fp_addsub_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [3:0]  flags;

  modport master (
    output in_valid, src1, src2, op, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, src1, src2, op, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/fp_lzc28.sv
// Combinational leading-zero count of a 28-bit word; an all-zero word reports 28.
module fp_lzc28 (
  input  logic [27:0] d,
  output logic [4:0]  cnt
);
  always_comb begin
    cnt = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (d[i]) cnt = 5'(27 - i);
    end
  end
endmodule

// File: rtl/fp_addsub_seq.sv
// Sequential IEEE-754 single add/subtract, one op in flight; out_valid rises five edges after accept.
// Result and flags are held in DONE until out_ready; in_ready is low in every state but IDLE.
module fp_addsub_seq
  import fp_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  fp_addsub_seq_if.slave bus
);
  localparam int MW = MAN_W + 1;
  localparam int XW = MW + 3;

  state_t                state;
  logic [31:0]           a_q, b_q;
  logic                  sign_q, eff_sub_q, zero_q, spec_q;
  logic signed [9:0]     exp_q;
  logic [XW-1:0]         ma_q, mb_q, nm_q;
  logic [XW:0]           sum_q;
  logic [31:0]           spec_val_q, res_q;
  logic [3:0]            spec_flg_q, res_flg_q;

  fclass_t               ca, cb;
  logic                  swap;
  logic [31:0]           mag_big;
  logic [30:0]           mag_sml;
  logic [8:0]            diff;
  logic [XW-1:0]         m_sml, mb_shift;
  logic                  spec_c;
  logic [31:0]           spec_val_c;
  logic [3:0]            spec_flg_c;

  // Alignment: larger magnitude becomes A, B shifts right keeping a sticky LSB.
  always_comb begin
    ca       = classify(a_q[30:0]);
    cb       = classify(b_q[30:0]);
    swap     = b_q[30:0] > a_q[30:0];
    mag_big  = swap ? b_q : a_q;
    mag_sml  = swap ? a_q[30:0] : b_q[30:0];
    diff     = {1'b0, mag_big[30:23]} - {1'b0, mag_sml[30:23]};
    m_sml    = {1'b1, mag_sml[22:0], 3'b000};
    if (diff >= 9'(XW))
      mb_shift = XW'(1);
    else
      mb_shift = (m_sml >> diff) | XW'(|(m_sml & ((XW'(1) << diff) - XW'(1))));
  end

  always_comb begin
    spec_c     = 1'b1;
    spec_val_c = QNAN;
    spec_flg_c = '0;
    if (ca == CL_NAN || cb == CL_NAN)
      spec_flg_c[FLG_INVALID] = 1'b1;
    else if (ca == CL_INF && cb == CL_INF && a_q[31] != b_q[31])
      spec_flg_c[FLG_INVALID] = 1'b1;
    else if (ca == CL_INF)
      spec_val_c = {a_q[31], EXP_MAX, {MAN_W{1'b0}}};
    else if (cb == CL_INF)
      spec_val_c = {b_q[31], EXP_MAX, {MAN_W{1'b0}}};
    else if (ca == CL_ZERO && cb == CL_ZERO)
      spec_val_c = {a_q[31] & b_q[31], 31'd0};
    else if (ca == CL_ZERO)
      spec_val_c = b_q;
    else if (cb == CL_ZERO)
      spec_val_c = a_q;
    else
      spec_c = 1'b0;
  end

  logic [4:0]        lz, sh;
  logic [XW-1:0]     nm_c;
  logic signed [9:0] exp_n_c;
  logic              zero_c;

  fp_lzc28 u_lzc (
    .d   (sum_q),
    .cnt (lz)
  );

  always_comb begin
    sh      = lz - 5'd1;
    nm_c    = '0;
    exp_n_c = exp_q;
    zero_c  = 1'b0;
    if (sum_q[XW]) begin
      nm_c    = {sum_q[XW:2], sum_q[1] | sum_q[0]};
      exp_n_c = exp_q + 10'sd1;
    end else if (sum_q == '0) begin
      zero_c  = 1'b1;
    end else begin
      nm_c    = sum_q[XW-1:0] << sh;
      exp_n_c = exp_q - $signed({5'd0, sh});
    end
  end

  logic              up, inex;
  logic [MW:0]       m_rnd;
  logic signed [9:0] exp_r;
  logic [MAN_W-1:0]  frac;
  logic [31:0]       res_c;
  logic [3:0]        res_flg_c;

  // Round to nearest even on {G,R,S} = nm_q[2:0]; exact cancellation yields +0.
  always_comb begin
    up        = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
    inex      = |nm_q[2:0];
    m_rnd     = {1'b0, nm_q[XW-1:3]} + {{MW{1'b0}}, up};
    exp_r     = m_rnd[MW] ? exp_q + 10'sd1 : exp_q;
    frac      = m_rnd[MW] ? m_rnd[MW-1:1] : m_rnd[MAN_W-1:0];
    res_c     = '0;
    res_flg_c = '0;
    if (spec_q) begin
      res_c     = spec_val_q;
      res_flg_c = spec_flg_q;
    end else if (zero_q) begin
      res_c     = '0;
    end else if (exp_r >= $signed({2'b00, EXP_MAX})) begin
      res_c                   = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
      res_flg_c[FLG_OVERFLOW] = 1'b1;
      res_flg_c[FLG_INEXACT]  = 1'b1;
    end else if (exp_r <= 10'sd0) begin
      res_c                    = {sign_q, 31'd0};
      res_flg_c[FLG_UNDERFLOW] = 1'b1;
      res_flg_c[FLG_INEXACT]   = 1'b1;
    end else begin
      res_c                  = {sign_q, exp_r[EXP_W-1:0], frac};
      res_flg_c[FLG_INEXACT] = inex;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
      bus.flags     <= '0;
      a_q           <= '0;
      b_q           <= '0;
      sign_q        <= 1'b0;
      eff_sub_q     <= 1'b0;
      zero_q        <= 1'b0;
      spec_q        <= 1'b0;
      exp_q         <= '0;
      ma_q          <= '0;
      mb_q          <= '0;
      nm_q          <= '0;
      sum_q         <= '0;
      spec_val_q    <= '0;
      spec_flg_q    <= '0;
      res_q         <= '0;
      res_flg_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            a_q          <= bus.src1;
            b_q          <= {bus.src2[31] ^ bus.op, bus.src2[30:0]};
            bus.in_ready <= 1'b0;
            state        <= ALIGN;
          end
        end
        ALIGN: begin
          sign_q     <= mag_big[31];
          eff_sub_q  <= a_q[31] ^ b_q[31];
          exp_q      <= $signed({2'b00, mag_big[30:23]});
          ma_q       <= {1'b1, mag_big[22:0], 3'b000};
          mb_q       <= mb_shift;
          spec_q     <= spec_c;
          spec_val_q <= spec_val_c;
          spec_flg_q <= spec_flg_c;
          state      <= ADD;
        end
        ADD: begin
          sum_q <= eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});
          state <= NORM;
        end
        NORM: begin
          nm_q   <= nm_c;
          exp_q  <= exp_n_c;
          zero_q <= zero_c;
          state  <= ROUND;
        end
        ROUND: begin
          res_q     <= res_c;
          res_flg_q <= res_flg_c;
          state     <= DONE;
        end
        DONE: begin
          // Outputs load on the first DONE edge, then hold until the consumer takes them.
          if (!bus.out_valid) begin
            bus.out       <= res_q;
            bus.flags     <= res_flg_q;
            bus.out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq: vector table through a scoreboard plus latency,
// backpressure and mid-operation reset sequences.
module tb_fp_addsub_seq;
  logic clk = 1'b0;
  logic rst;

  fp_addsub_seq_if bus ();

  fp_addsub_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t        vecs[$];
  logic [35:0] sb[$];
  logic [35:0] sb_head;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] r, input logic [3:0] f);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.r = r; v.f = f;
    vecs.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [31:0] r, input logic [3:0] f);
    int t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL issue_timeout: in_ready still %b after %0d cycles, expected 1", bus.in_ready, t);
    end else begin
      bus.src1     = a;
      bus.src2     = b;
      bus.op       = op;
      bus.in_valid = 1'b1;
      sb.push_back({r, f});
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || bus.out_valid) begin
      n_checks++;
      $display("FAIL %s: %0d results outstanding after %0d cycles, expected 0", name, sb.size(), t);
    end
  endtask

  // Result monitor: a transfer happens on the edge after out_valid & out_ready are seen here.
  always begin
    @(negedge clk);
    #1;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got out=%h flags=%h, expected no result", bus.out, bus.flags);
      end else begin
        sb_head = sb.pop_front();
        chk("result {out,flags}", {28'd0, bus.out, bus.flags}, {28'd0, sb_head});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.op        = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_state {in_ready,out_valid,flags,out}",
        {26'd0, bus.in_ready, bus.out_valid, bus.flags, bus.out},
        {26'd0, 1'b1, 1'b0, 4'h0, 32'h0});
    rst = 1'b0;
    @(negedge clk);

    // Latency: accept edge N, out_valid first seen at the 6th negedge (after edge N+5).
    bus.src1     = 32'h4080_0000;
    bus.src2     = 32'hC040_0000;
    bus.op       = 1'b1;
    bus.in_valid = 1'b1;
    sb.push_back({32'h40E0_0000, 4'h0});
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.in_valid = 1'b0;
      if (bus.out_valid && lat == 0) lat = k;
    end
    chk("latency_negedges", 64'(lat), 64'd6);
    wait_drain("latency_drain");

    add_vec(32'h4080_0000, 32'hC040_0000, 1'b1, 32'h40E0_0000, 4'h0);
    add_vec(32'hC080_0000, 32'h4040_0000, 1'b1, 32'hC0E0_0000, 4'h0);
    add_vec(32'hC080_0000, 32'hC040_0000, 1'b1, 32'hBF80_0000, 4'h0);
    add_vec(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 4'h1);
    add_vec(32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001, 4'h1);
    add_vec(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h0000_0000, 4'h0);
    add_vec(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'h8);
    add_vec(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'h5);
    add_vec(32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'h8);
    add_vec(32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 4'h0);
    add_vec(32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, 4'h0);
    add_vec(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'h0);
    add_vec(32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 4'h0);
    add_vec(32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 4'h0);
    add_vec(32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 4'h3);
    add_vec(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 4'h0);
    add_vec(32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 32'h3380_0000, 4'h0);
    add_vec(32'h3F7F_FFFF, 32'h3300_0000, 1'b0, 32'h3F80_0000, 4'h1);
    foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, vecs[i].f);
    wait_drain("table_drain");

    // Backpressure: result held stable, new requests ignored until IDLE.
    bus.out_ready = 1'b0;
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 4'h0);
    for (int t = 0; t < 20 && !bus.out_valid; t++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      chk("backpressure_hold {out_valid,in_ready,out}",
          {30'd0, bus.out_valid, bus.in_ready, bus.out},
          {30'd0, 1'b1, 1'b0, 32'h4000_0000});
      if (k == 2) begin
        bus.src1     = 32'h4040_0000;
        bus.src2     = 32'h4040_0000;
        bus.op       = 1'b0;
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("ready_after_done {in_ready,out_valid}", {62'd0, bus.in_ready, bus.out_valid}, {62'd0, 2'b10});
    issue(32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4080_0000, 4'h0);
    wait_drain("backpressure_drain");

    // Reset asserted while the op sits in NORM (third negedge after accept).
    bus.src1     = 32'h3F80_0000;
    bus.src2     = 32'h4000_0000;
    bus.op       = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) bus.in_valid = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("async_reset {in_ready,out_valid,flags,out}",
        {26'd0, bus.in_ready, bus.out_valid, bus.flags, bus.out},
        {26'd0, 1'b1, 1'b0, 4'h0, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(32'h40A0_0000, 32'h3F80_0000, 1'b1, 32'h4080_0000, 4'h0);
    wait_drain("post_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
